// File: rtl/rv32i_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between instruction fetch and load/store.
// Optional stall performance counters are built only when MEM_ARB_PERF_EN is defined.
module rv32i_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IF_req,
  input  logic [31:0] IF_addr,
  output logic        IF_gnt,
  output logic        IF_rvalid,
  output logic [31:0] IF_rdata,
  input  logic        MEM_req,
  input  logic        MEM_we,
  input  logic [3:0]  MEM_be,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_wdata,
  output logic        MEM_gnt,
  output logic        MEM_rvalid,
  output logic [31:0] MEM_rdata,
  input  logic        Flush,
  output logic        BUS_req,
  output logic        BUS_we,
  output logic [3:0]  BUS_be,
  output logic [31:0] BUS_addr,
  output logic [31:0] BUS_wdata,
  input  logic        BUS_gnt,
  input  logic        BUS_rvalid,
  input  logic [31:0] BUS_rdata,
  output logic [31:0] IF_stall_cnt,
  output logic [31:0] MEM_stall_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_IF,
    ADDR_MEM,
    DATA_IF,
    DATA_MEM
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        drop_q, drop_d;
  logic        own_if, own_mem;
  logic        addr_phase, data_phase, resp;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
    end
  end

  // Ownership: chosen combinationally in IDLE, then locked until the response returns.
  always_comb begin
    own_if  = 1'b0;
    own_mem = 1'b0;
    case (state_q)
      IDLE: begin
        if (IF_req && MEM_req) begin
          if (starve_cnt_q == LIMIT) own_if = 1'b1;
          else                       own_mem = 1'b1;
        end else begin
          own_if  = IF_req;
          own_mem = MEM_req;
        end
      end
      ADDR_IF, DATA_IF:   own_if  = 1'b1;
      ADDR_MEM, DATA_MEM: own_mem = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    addr_phase   = (state_q == IDLE) || (state_q == ADDR_IF) || (state_q == ADDR_MEM);
    data_phase   = (state_q == DATA_IF) || (state_q == DATA_MEM);
    resp         = data_phase && BUS_rvalid;

    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    drop_d       = drop_q;
    BUS_req      = 1'b0;
    BUS_we       = 1'b0;
    BUS_be       = 4'h0;
    BUS_addr     = 32'h0;
    BUS_wdata    = 32'h0;
    IF_gnt       = 1'b0;
    MEM_gnt      = 1'b0;
    IF_rvalid    = 1'b0;
    IF_rdata     = 32'h0;
    MEM_rvalid   = 1'b0;
    MEM_rdata    = 32'h0;

    if (addr_phase && own_if) begin
      BUS_req  = 1'b1;
      BUS_be   = 4'hF;
      BUS_addr = IF_addr;
      IF_gnt   = BUS_gnt;
      state_d  = BUS_gnt ? DATA_IF : ADDR_IF;
    end else if (addr_phase && own_mem) begin
      BUS_req   = 1'b1;
      BUS_we    = MEM_we;
      BUS_be    = MEM_be;
      BUS_addr  = MEM_addr;
      BUS_wdata = MEM_wdata;
      MEM_gnt   = BUS_gnt;
      state_d   = BUS_gnt ? DATA_MEM : ADDR_MEM;
    end

    // A flush anywhere in the fetch's lifetime, including the response cycle, hides its data.
    if (own_if && Flush) drop_d = 1'b1;
    if (resp) begin
      state_d = IDLE;
      drop_d  = 1'b0;
      if (own_if && !(drop_q || Flush)) begin
        IF_rvalid = 1'b1;
        IF_rdata  = BUS_rdata;
      end
      if (own_mem) begin
        MEM_rvalid = 1'b1;
        MEM_rdata  = BUS_rdata;
      end
    end

    if (!IF_req || IF_gnt)                        starve_cnt_d = 4'd0;
    else if (MEM_gnt && (starve_cnt_q < LIMIT))   starve_cnt_d = starve_cnt_q + 4'd1;

    // Outputs stay quiet for the whole reset pulse, even with requests pending.
    if (Reset) begin
      BUS_req    = 1'b0;
      BUS_we     = 1'b0;
      BUS_be     = 4'h0;
      BUS_addr   = 32'h0;
      BUS_wdata  = 32'h0;
      IF_gnt     = 1'b0;
      MEM_gnt    = 1'b0;
      IF_rvalid  = 1'b0;
      IF_rdata   = 32'h0;
      MEM_rvalid = 1'b0;
      MEM_rdata  = 32'h0;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] if_stall_q, if_stall_d;
  logic [31:0] mem_stall_q, mem_stall_d;

  always_comb begin
    if_stall_d  = if_stall_q;
    mem_stall_d = mem_stall_q;
    if (IF_req && !IF_gnt && (if_stall_q != 32'hFFFF_FFFF))     if_stall_d  = if_stall_q + 32'd1;
    if (MEM_req && !MEM_gnt && (mem_stall_q != 32'hFFFF_FFFF))  mem_stall_d = mem_stall_q + 32'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      if_stall_q  <= 32'h0;
      mem_stall_q <= 32'h0;
    end else begin
      if_stall_q  <= if_stall_d;
      mem_stall_q <= mem_stall_d;
    end
  end

  assign IF_stall_cnt  = if_stall_q;
  assign MEM_stall_cnt = mem_stall_q;
`else
  assign IF_stall_cnt  = 32'h0;
  assign MEM_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: directed scenarios then randomized masters and memory,
// all checked against a transaction-level model of ownership, starvation and flush.
module tb_rv32i_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, mem_req, mem_we, flush, bus_gnt, bus_rvalid;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_be;
  logic        IF_gnt, IF_rvalid, MEM_gnt, MEM_rvalid;
  logic        BUS_req, BUS_we;
  logic [3:0]  BUS_be;
  logic [31:0] IF_rdata, MEM_rdata, BUS_addr, BUS_wdata, IF_stall_cnt, MEM_stall_cnt;

  int errors = 0;
  int checks = 0;

  // Model: who owns the bus (0 none, 1 fetch, 2 load/store), whether the request was accepted.
  int          m_owner = 0;
  bit          m_wait = 0;
  int          m_starve = 0;
  bit          m_drop = 0;
  logic [31:0] m_if_stall = 0, m_mem_stall = 0;
  bit          e_if_gnt, e_mem_gnt, e_if_rvalid, e_mem_rvalid, e_bus_req;

  rv32i_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .Clk(clk), .Reset(reset),
    .IF_req(if_req), .IF_addr(if_addr), .IF_gnt(IF_gnt), .IF_rvalid(IF_rvalid), .IF_rdata(IF_rdata),
    .MEM_req(mem_req), .MEM_we(mem_we), .MEM_be(mem_be), .MEM_addr(mem_addr), .MEM_wdata(mem_wdata),
    .MEM_gnt(MEM_gnt), .MEM_rvalid(MEM_rvalid), .MEM_rdata(MEM_rdata),
    .Flush(flush),
    .BUS_req(BUS_req), .BUS_we(BUS_we), .BUS_be(BUS_be), .BUS_addr(BUS_addr), .BUS_wdata(BUS_wdata),
    .BUS_gnt(bus_gnt), .BUS_rvalid(bus_rvalid), .BUS_rdata(bus_rdata),
    .IF_stall_cnt(IF_stall_cnt), .MEM_stall_cnt(MEM_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    m_owner = 0; m_wait = 0; m_starve = 0; m_drop = 0;
    m_if_stall = 0; m_mem_stall = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, predict and compare, advance the model.
  task automatic applyStimulus(
    input logic rst_i, input logic if_req_i, input logic [31:0] if_addr_i,
    input logic mem_req_i, input logic mem_we_i, input logic [3:0] mem_be_i,
    input logic [31:0] mem_addr_i, input logic [31:0] mem_wdata_i,
    input logic gnt_i, input logic rvalid_i, input logic [31:0] rdata_i, input logic flush_i);
    int own;
    bit hs, resp;
    @(negedge clk);
    reset = rst_i; if_req = if_req_i; if_addr = if_addr_i;
    mem_req = mem_req_i; mem_we = mem_we_i; mem_be = mem_be_i; mem_addr = mem_addr_i; mem_wdata = mem_wdata_i;
    bus_gnt = gnt_i; bus_rvalid = rvalid_i; bus_rdata = rdata_i; flush = flush_i;
    #1;
    own = m_owner;
    if (m_owner == 0) begin
      if (if_req_i && mem_req_i) own = (m_starve == LIMIT) ? 1 : 2;
      else if (if_req_i)         own = 1;
      else if (mem_req_i)        own = 2;
    end
    if (rst_i) own = 0;
    e_bus_req    = (own != 0) && !m_wait;
    hs           = e_bus_req && gnt_i;
    resp         = m_wait && rvalid_i && !rst_i;
    e_if_gnt     = hs && (own == 1);
    e_mem_gnt    = hs && (own == 2);
    e_if_rvalid  = resp && (own == 1) && !(m_drop || flush_i);
    e_mem_rvalid = resp && (own == 2);

    checkOutput("bus_req", {31'h0, BUS_req}, {31'h0, e_bus_req});
    checkOutput("if_gnt", {31'h0, IF_gnt}, {31'h0, e_if_gnt});
    checkOutput("mem_gnt", {31'h0, MEM_gnt}, {31'h0, e_mem_gnt});
    checkOutput("if_rvalid", {31'h0, IF_rvalid}, {31'h0, e_if_rvalid});
    checkOutput("mem_rvalid", {31'h0, MEM_rvalid}, {31'h0, e_mem_rvalid});
    if (e_if_rvalid || own != 1) checkOutput("if_rdata", IF_rdata, e_if_rvalid ? rdata_i : 32'h0);
    if (e_mem_rvalid || own != 2) checkOutput("mem_rdata", MEM_rdata, e_mem_rvalid ? rdata_i : 32'h0);
    if (e_bus_req) begin
      checkOutput("bus_addr", BUS_addr, (own == 1) ? if_addr_i : mem_addr_i);
      checkOutput("bus_we", {31'h0, BUS_we}, (own == 1) ? 32'h0 : {31'h0, mem_we_i});
      checkOutput("bus_be", {28'h0, BUS_be}, (own == 1) ? 32'hF : {28'h0, mem_be_i});
      checkOutput("bus_wdata", BUS_wdata, (own == 1) ? 32'h0 : mem_wdata_i);
    end
`ifdef MEM_ARB_PERF_EN
    checkOutput("if_stall_cnt", IF_stall_cnt, m_if_stall);
    checkOutput("mem_stall_cnt", MEM_stall_cnt, m_mem_stall);
`else
    checkOutput("if_stall_cnt", IF_stall_cnt, 32'h0);
    checkOutput("mem_stall_cnt", MEM_stall_cnt, 32'h0);
`endif

    if (rst_i) begin
      clearModel();
    end else begin
      if (if_req_i && !e_if_gnt)   m_if_stall++;
      if (mem_req_i && !e_mem_gnt) m_mem_stall++;
      if (!if_req_i || e_if_gnt)             m_starve = 0;
      else if (e_mem_gnt && m_starve < LIMIT) m_starve++;
      if (resp) begin
        m_owner = 0; m_wait = 0; m_drop = 0;
      end else begin
        m_owner = own;
        if (hs) m_wait = 1;
        if (own == 1 && flush_i) m_drop = 1;
      end
    end
  endtask

  task automatic idleCycle(input logic rvalid_i);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, rvalid_i, 32'hDEAD_BEEF, 0);
  endtask

  task automatic doReset();
    applyStimulus(1, 1, 32'h44, 1, 1, 4'hF, 32'h88, 32'h1, 1, 1, 32'h5, 0);
    checkOutput("rst_outputs", {27'h0, BUS_req, IF_gnt, MEM_gnt, IF_rvalid, MEM_rvalid}, 32'h0);
    idleCycle(0);
  endtask

  logic        r_if_req, r_mem_req, r_mem_we, r_rst;
  logic [31:0] r_if_addr, r_mem_addr, r_mem_wdata, seq;
  logic [3:0]  r_mem_be;
  int          ngrants;

  initial begin
    reset = 1'b1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_be = 0;
    mem_addr = 0; mem_wdata = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; flush = 0;
    doReset();

    $display("[TB] single fetch");
    applyStimulus(0, 1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("fetch_gnt", {31'h0, IF_gnt}, 32'h1);
    checkOutput("fetch_addr", BUS_addr, 32'h10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0010_0293, 0);
    checkOutput("fetch_rvalid", {31'h0, IF_rvalid}, 32'h1);
    checkOutput("fetch_rdata", IF_rdata, 32'h0010_0293);
    idleCycle(0);
    checkOutput("fetch_rvalid_after", {31'h0, IF_rvalid}, 32'h0);

    $display("[TB] contention");
    applyStimulus(0, 1, 32'h14, 1, 0, 4'hF, 32'h200, 0, 1, 0, 0, 0);
    checkOutput("cont_mem_first", {30'h0, IF_gnt, MEM_gnt}, 32'h1);
    checkOutput("cont_addr", BUS_addr, 32'h200);
    applyStimulus(0, 1, 32'h14, 0, 0, 0, 0, 0, 1, 1, 32'hCAFE_0001, 0);
    checkOutput("cont_mem_rvalid", {30'h0, MEM_rvalid, IF_gnt}, 32'h2);
    applyStimulus(0, 1, 32'h14, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("cont_if_second", {31'h0, IF_gnt}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234, 0);

    $display("[TB] starvation guard");
    doReset();
    seq = 0; ngrants = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1, 32'h80, 1, 0, 4'hF, 32'h300, 0, 1, 1, 32'h77, 0);
      if (IF_gnt || MEM_gnt) begin
        seq = {seq[30:0], IF_gnt};
        ngrants++;
      end
    end
    checkOutput("starve_grants", ngrants, 6);
    checkOutput("starve_order", seq, 32'b000010);

    $display("[TB] ownership lock");
    doReset();
    applyStimulus(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h40, 1, 1, 4'hF, 32'h500, 32'hAA, 0, 0, 0, 0);
    checkOutput("lock_addr1", BUS_addr, 32'h40);
    applyStimulus(0, 1, 32'h40, 1, 1, 4'hF, 32'h500, 32'hAA, 0, 0, 0, 0);
    checkOutput("lock_addr2", BUS_addr, 32'h40);
    applyStimulus(0, 1, 32'h40, 1, 1, 4'hF, 32'h500, 32'hAA, 1, 0, 0, 0);
    checkOutput("lock_if_gnt", {30'h0, IF_gnt, MEM_gnt}, 32'h2);
    applyStimulus(0, 0, 0, 1, 1, 4'hF, 32'h500, 32'hAA, 1, 1, 32'h9, 0);
    applyStimulus(0, 0, 0, 1, 1, 4'hF, 32'h500, 32'hAA, 1, 0, 0, 0);
    checkOutput("lock_mem_later", {31'h0, MEM_gnt}, 32'h1);
    idleCycle(1);

    $display("[TB] flush");
    applyStimulus(0, 1, 32'h20, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idleCycle(0);
    idleCycle(1);
    checkOutput("flush_dropped", {31'h0, IF_rvalid}, 32'h0);
    applyStimulus(0, 1, 32'h24, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 0);
    checkOutput("flush_next_rvalid", {31'h0, IF_rvalid}, 32'h1);
    checkOutput("flush_next_rdata", IF_rdata, 32'h1234_5678);

    $display("[TB] reset mid-transaction");
    applyStimulus(0, 0, 0, 1, 0, 4'hF, 32'h600, 0, 1, 0, 0, 0);
    idleCycle(0);
    #1 reset = 1'b1;
    #1 checkOutput("async_rst_quiet", {30'h0, BUS_req, MEM_rvalid}, 32'h0);
    reset = 1'b0;
    clearModel();
    idleCycle(1);
    checkOutput("stray_rvalid", {31'h0, MEM_rvalid}, 32'h0);
    applyStimulus(0, 0, 0, 1, 1, 4'b0011, 32'h604, 32'h5555_AAAA, 1, 0, 0, 0);
    checkOutput("store_be", {28'h0, BUS_be}, 32'h3);
    checkOutput("store_gnt", {31'h0, MEM_gnt}, 32'h1);
    idleCycle(1);
    checkOutput("store_done", {31'h0, MEM_rvalid}, 32'h1);

    $display("[TB] randomized traffic");
    r_if_req = 0; r_mem_req = 0; r_if_addr = 0; r_mem_addr = 0; r_mem_wdata = 0; r_mem_we = 0; r_mem_be = 0;
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      if (!r_if_req && $urandom_range(0, 2) == 0) begin
        r_if_req = 1; r_if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!r_mem_req && $urandom_range(0, 2) == 0) begin
        r_mem_req = 1; r_mem_addr = $urandom; r_mem_wdata = $urandom;
        r_mem_we = 1'($urandom_range(0, 1)); r_mem_be = 4'($urandom_range(0, 15));
      end
      applyStimulus(r_rst, r_if_req, r_if_addr, r_mem_req, r_mem_we, r_mem_be, r_mem_addr, r_mem_wdata,
                    $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 7) == 0);
      if (e_if_gnt || r_rst)  r_if_req = 0;
      if (e_mem_gnt || r_rst) r_mem_req = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
Shares one single-ported memory bus between the pipeline's instruction-fetch (IF) port and the load/store (MEM) port. Only one transaction is outstanding at a time. MEM gets fixed priority, with a starvation guard that guarantees IF forward progress. IF responses are squashed on a pipeline flush. The block sits between IF/MEM stages of the RV32I core and the unified memory.

Parameters:
STARVE_LIMIT, 4, consecutive MEM grants allowed while IF_req is pending before IF is forced to win (1..15)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
IF_req  in  1  fetch request; held with IF_addr stable until IF_gnt
IF_addr  in  32  fetch word address
IF_gnt  out  1  fetch accepted by bus this cycle
IF_rvalid  out  1  fetch data valid
IF_rdata  out  32  fetch data
MEM_req  in  1  load/store request; held with attributes stable until MEM_gnt
MEM_we  in  1  1 = store
MEM_be  in  4  byte enables
MEM_addr  in  32  data address
MEM_wdata  in  32  store data
MEM_gnt  out  1  load/store accepted
MEM_rvalid  out  1  load data valid / store complete
MEM_rdata  out  32  load data
Flush  in  1  squash the in-flight fetch response
BUS_req, BUS_we, BUS_be[4], BUS_addr[32], BUS_wdata[32]  out  -  memory request channel
BUS_gnt  in  1  memory accepts request (BUS_req & BUS_gnt = handshake)
BUS_rvalid  in  1  response valid, earliest the cycle after handshake
BUS_rdata  in  32  response data
IF_stall_cnt  out  32  perf counter (see Optional Feature)
MEM_stall_cnt  out  32  perf counter

Behaviour:
- States:
  - IDLE
  - ADDR_IF, ADDR_MEM: owner chosen, BUS_req held until BUS_gnt
  - DATA_IF, DATA_MEM: waiting for BUS_rvalid
- IDLE, selection is combinational in the same cycle:
  - Only one requester high: that requester is the owner.
  - Both high: MEM is the owner unless starve_cnt == STARVE_LIMIT, in which case IF is the owner.
  - Owner's attributes drive BUS_*; BUS_req=1. For IF: BUS_we=0, BUS_be=4'hF, BUS_wdata=0.
  - BUS_gnt=1: owner's gnt=1 → DATA_x.
  - BUS_gnt=0 → ADDR_x, owner locked. No switching even if the other requester rises.
- ADDR_x: BUS_req=1 with the locked owner's attributes; on BUS_gnt, owner gnt=1 → DATA_x.
- DATA_x: BUS_req=0. On BUS_rvalid:
  - x_rvalid=1 and x_rdata=BUS_rdata, combinational (zero added latency).
  - Next state IDLE. Minimum transaction: 2 cycles. Back-to-back is allowed from IDLE on the following cycle.
- Non-owner rvalid=0, rdata=32'h0. gnt only ever asserts for the owner.
- BUS_rvalid in IDLE or ADDR_x is ignored (stale response after reset).
- starve_cnt (4 bits):
  - +1 on each MEM handshake while IF_req=1.
  - Cleared on IF handshake or any cycle with IF_req=0.
  - Saturates at STARVE_LIMIT.
- Flush:
  - Asserted in any cycle from IF selection through the DATA_IF rvalid cycle inclusive, it sets drop.
  - drop forces IF_rvalid=0 for that fetch's response. The bus transaction still completes normally.
  - Flush in the same cycle as BUS_rvalid also suppresses.
  - drop clears on return to IDLE. Flush has no effect on MEM transactions.
- Reset (asynchronous, any state): state=IDLE, starve_cnt=0, drop=0, counters=0. While Reset=1, all outputs are forced to 0: BUS_req, gnts, rvalids, rdata.
- Reset mid-transaction abandons it. A subsequent stray BUS_rvalid is ignored per the rule above.

Optional Feature:
MEM_ARB_PERF_EN:
- Defined:
  - IF_stall_cnt increments each cycle with IF_req=1 & IF_gnt=0.
  - MEM_stall_cnt increments each cycle with MEM_req=1 & MEM_gnt=0.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports are tied to 32'h0 and no counter flops exist.

Test Plan:
- Single fetch: IF_req, IF_addr=0x10, BUS_gnt same cycle, BUS_rvalid next cycle with 0x00100293 → IF_gnt in cycle 0; IF_rvalid=1 with IF_rdata=0x00100293 in cycle 1; IF_rvalid=0 in cycle 2.
- Contention: IF_req and MEM_req (load 0x200) rise together, bus always ready, 1-cycle response → MEM granted first, IF granted in the cycle after MEM_rvalid.
- Starvation: IF_req held, MEM_req held continuously, STARVE_LIMIT=4 → exactly 4 MEM grants, then 1 IF grant, then MEM resumes.
- Ownership lock: BUS_gnt=0 for 3 cycles after the IF request; MEM_req rises in cycle 1 → BUS_addr stays IF_addr; IF is granted in cycle 3; MEM waits.
- Flush: IF handshake, Flush pulses in DATA_IF, BUS_rvalid two cycles later → IF_rvalid stays 0; the next fetch returns data normally.
- Reset mid-op: Reset pulses in DATA_MEM, then a stray BUS_rvalid → MEM_rvalid=0; state IDLE; a fresh MEM store (be=4'b0011) completes with BUS_be=4'b0011.
